// File: rtl/tapped_shift_line.sv
// tapped_shift_line: DEPTH x WIDTH shift line with random-access tap and fill tracking; define TAP_REG_EN to register the tap outputs.
module tapped_shift_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [CW-1:0]    fill,
   output logic             full
);
   logic [WIDTH-1:0] stage [DEPTH];
   logic [WIDTH-1:0] tap_d;
   logic             tap_v;
   logic             in_rng;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         fill <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         fill <= '0;
      end else if (enable) begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
         fill <= full ? fill : fill + CW'(1);
      end
   end
   assign full = fill == CW'(DEPTH);
   // addr can exceed DEPTH-1 only when DEPTH is not a power of two
   assign in_rng = CW'(addr) < CW'(DEPTH);
   assign tap_d  = in_rng ? stage[addr] : '0;
   assign tap_v  = CW'(addr) < fill;
`ifdef TAP_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout       <= clear ? '0 : tap_d;
         dout_valid <= clear ? 1'b0 : tap_v;
      end
   end
`else
   assign dout       = tap_d;
   assign dout_valid = tap_v;
`endif
endmodule

// File: tb/tb_tapped_shift_line.sv
// tb_tapped_shift_line: directed checks of tapped_shift_line at DEPTH=8 and DEPTH=6.
module tb_tapped_shift_line;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable, clear;
   logic [3:0] din;
   logic [2:0] addr;
   logic [3:0] dout;
   logic       dout_valid;
   logic [3:0] fill;
   logic       full;
   logic       en6, clr6;
   logic [3:0] din6;
   logic [2:0] addr6;
   logic [3:0] dout6;
   logic       v6;
   logic [2:0] fill6;
   logic       full6;
   int n_cmp = 0;
   int n_err = 0;

   tapped_shift_line #(.WIDTH(4), .DEPTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .din(din), .addr(addr),
      .dout(dout), .dout_valid(dout_valid), .fill(fill), .full(full));

   tapped_shift_line #(.WIDTH(4), .DEPTH(6)) u6 (
      .clk(clk), .rst_n(rst_n), .enable(en6), .clear(clr6), .din(din6), .addr(addr6),
      .dout(dout6), .dout_valid(v6), .fill(fill6), .full(full6));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tap(input int a, input int d, input int v);
      addr = 3'(a);
`ifdef TAP_REG_EN
      @(posedge clk);
`endif
      #1;
      chk($sformatf("dout@%0d", a), int'(dout), d);
      chk($sformatf("valid@%0d", a), int'(dout_valid), v);
   endtask

   task automatic tap6(input int a, input int d, input int v);
      addr6 = 3'(a);
`ifdef TAP_REG_EN
      @(posedge clk);
`endif
      #1;
      chk($sformatf("d6 dout@%0d", a), int'(dout6), d);
      chk($sformatf("d6 valid@%0d", a), int'(v6), v);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; clear = 1'b0; din = '0; addr = '0;
      en6 = 1'b0; clr6 = 1'b0; din6 = '0; addr6 = '0;
      #12;
      chk("rst fill", int'(fill), 0);
      chk("rst full", int'(full), 0);
      chk("rst dout", int'(dout), 0);
      chk("rst valid", int'(dout_valid), 0);
      @(negedge clk) rst_n = 1'b1;
      // 1. fill from empty
      for (int i = 1; i <= 8; i++) begin
         enable = 1'b1; din = 4'(i);
         step();
         chk($sformatf("fill after %0d", i), int'(fill), i);
         chk($sformatf("full after %0d", i), int'(full), i == 8 ? 1 : 0);
      end
      enable = 1'b0;
      for (int k = 0; k < 8; k++) tap(k, 8 - k, 1);
      // 3. hold, then saturate
      repeat (5) step();
      chk("hold fill", int'(fill), 8);
      tap(0, 8, 1);
      tap(7, 1, 1);
      for (int i = 9; i <= 12; i++) begin
         enable = 1'b1; din = 4'(i);
         step();
      end
      enable = 1'b0;
      chk("sat fill", int'(fill), 8);
      chk("sat full", int'(full), 1);
      tap(0, 12, 1);
      tap(3, 9, 1);
      tap(4, 8, 1);
      tap(7, 5, 1);
      // 4. clear beats enable
      clear = 1'b1; enable = 1'b1; din = 4'hF;
      step();
      clear = 1'b0; enable = 1'b0;
      chk("clr fill", int'(fill), 0);
      chk("clr full", int'(full), 0);
      for (int k = 0; k < 8; k++) tap(k, 0, 0);
      // 2. partial fill
      for (int i = 0; i < 3; i++) begin
         enable = 1'b1; din = 4'hA + 4'(i);
         step();
      end
      enable = 1'b0;
      chk("part fill", int'(fill), 3);
      tap(0, 4'hC, 1);
      tap(2, 4'hA, 1);
      tap(3, 0, 0);
      // 5. async reset mid-run
      for (int i = 0; i < 2; i++) begin
         enable = 1'b1; din = 4'hD + 4'(i);
         step();
      end
      chk("pre-rst fill", int'(fill), 5);
      addr = 3'd0;
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("arst fill", int'(fill), 0);
      chk("arst dout", int'(dout), 0);
      chk("arst valid", int'(dout_valid), 0);
      chk("arst full", int'(full), 0);
      @(negedge clk) rst_n = 1'b1;
      din = 4'h7;
      step();
      enable = 1'b0;
      chk("restart fill", int'(fill), 1);
      tap(0, 7, 1);
      tap(1, 0, 0);
      // 6. DEPTH=6 out-of-range taps
      for (int i = 1; i <= 6; i++) begin
         en6 = 1'b1; din6 = 4'(i);
         step();
      end
      en6 = 1'b0;
      chk("d6 fill", int'(fill6), 6);
      chk("d6 full", int'(full6), 1);
      for (int k = 0; k < 6; k++) tap6(k, 6 - k, 1);
      tap6(6, 0, 0);
      tap6(7, 0, 0);
`ifdef TAP_REG_EN
      addr6 = 3'd0;
      step();
      addr6 = 3'd5;
      #1;
      chk("d6 lat old", int'(dout6), 6);
      step();
      chk("d6 lat new", int'(dout6), 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
